// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared scheduler state encoding, defaults and frame types
// Contents:
//   sched_state_t  IDLE/CHECK/XFER/GAP scheduler states
//   DEF_HIGH_WM    default FIFO fill ceiling after a complete frame
//   IDX_W          producer index width (covers up to four producers)
//   frame_len_t    8-bit frame length, shared with the framers
//   fill_after()   FIFO fill level once a frame of a given length is written
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  localparam int DEF_HIGH_WM = 2000;
  localparam int IDX_W       = 2;

  typedef logic [7:0]       frame_len_t;
  typedef logic [IDX_W-1:0] req_idx_t;

  // 13 bits so a nearly full 12-bit level plus a long frame cannot wrap.
  function automatic logic [12:0] fill_after(input logic [11:0] usedw, input frame_len_t len);
    return {1'b0, usedw} + {5'b0, len};
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - TX FIFO write port shared by the frame scheduler
// Signals:
//   tx_fifo_wen    write strobe (scheduler -> FIFO)
//   tx_fifo_wdata  write byte   (scheduler -> FIFO)
//   tx_fifo_full   FIFO full    (FIFO -> scheduler)
//   tx_fifo_usedw  fill level   (FIFO -> scheduler)
// Modports: master = scheduler side, slave = FIFO side.
interface uart_tx_sched_if;

  logic        tx_fifo_wen;
  logic [7:0]  tx_fifo_wdata;
  logic        tx_fifo_full;
  logic [11:0] tx_fifo_usedw;

  modport master (
    output tx_fifo_wen,
    output tx_fifo_wdata,
    input  tx_fifo_full,
    input  tx_fifo_usedw
  );

  modport slave (
    input  tx_fifo_wen,
    input  tx_fifo_wdata,
    output tx_fifo_full,
    output tx_fifo_usedw
  );

endinterface

// File: rtl/uart_tx_sched_rr_pick.sv
// rtl/uart_tx_sched_rr_pick.sv - combinational round-robin selector over N_REQ requests
// Ports:
//   req      in   N_REQ  request vector
//   last     in   IDX_W  index granted most recently; search starts at last+1
//   win_oh   out  N_REQ  one-hot winner (zero when no request)
//   win_idx  out  IDX_W  winner index
//   win_vld  out  1      any request present
module uart_tx_sched_rr_pick
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         last,
  output logic [N_REQ-1:0] win_oh,
  output req_idx_t         win_idx,
  output logic             win_vld
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] pos;

  // Walk offsets 1..N_REQ from last; the first requester found wins, so the
  // previous winner is considered only after everyone else.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    pos     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = {1'b0, last} + SUM_W'(k);
      if (pos >= SUM_W'(N_REQ)) pos = pos - SUM_W'(N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (!win_vld && req[j] && (pos == SUM_W'(j))) begin
          win_vld   = 1'b1;
          win_oh[j] = 1'b1;
          win_idx   = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - frame-atomic round-robin scheduler onto one UART TX FIFO write port
// Ports:
//   clk         in   1        system clock
//   rst         in   1        asynchronous active-low reset
//   ena         in   1        enables new grants; a frame in progress always completes
//   req         in   N_REQ    producer i holds a complete frame
//   req_len     in   8*N_REQ  frame length of producer i, slice [8i+7:8i]
//   src_data    in   8*N_REQ  current byte of producer i
//   gnt         out  N_REQ    registered one-hot grant
//   src_ack     out  N_REQ    byte consumed this cycle (combinational)
//   frame_done  out  N_REQ    one-cycle pulse after a frame's last byte
//   err_stall   out  1        one pulse per stall episode reaching STALL_LIM
//   fifo        master       TX FIFO write port (wen/wdata registered, full/usedw in)
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int HIGH_WM   = DEF_HIGH_WM,
  parameter int STALL_LIM = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_len,
  input  logic [8*N_REQ-1:0]   src_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     src_ack,
  output logic [N_REQ-1:0]     frame_done,
  output logic                 err_stall,
  uart_tx_sched_if.master      fifo
);

  sched_state_t     state, state_nxt;
  req_idx_t         win_idx, last, pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_vld;
  frame_len_t       rem, pick_len;
  logic [7:0]       sel_byte;
  logic [7:0]       stall_cnt;
  logic             gap_cnt;
  logic             do_grant, do_finish, do_write, last_byte;

  uart_tx_sched_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req     (req),
    .last    (last),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  // Byte lane of the current owner, and length lane of the candidate winner.
  always_comb begin
    sel_byte = '0;
    pick_len = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i))  sel_byte = src_data[8*i +: 8];
      if (pick_idx == IDX_W'(i)) pick_len = req_len[8*i +: 8];
    end
  end

  // full is looked at in the same cycle, so a blocked cycle never acks a byte.
  assign do_write  = (state == XFER) && !fifo.tx_fifo_full;
  assign src_ack   = do_write ? gnt : '0;
  assign last_byte = do_write && (rem == 8'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_finish = 1'b0;
    case (state)
      IDLE: begin
        if (ena && pick_vld) begin
          do_grant  = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        // Grant stays held while waiting for room; no re-arbitration here.
        if (rem == '0) begin
          do_finish = 1'b1;
          state_nxt = GAP;
        end else if (fill_after(fifo.tx_fifo_usedw, rem) <= 13'(HIGH_WM)) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (last_byte) begin
          do_finish = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt                <= '0;
      frame_done         <= '0;
      win_idx            <= '0;
      last               <= IDX_W'(N_REQ - 1);
      rem                <= '0;
      gap_cnt            <= 1'b0;
      fifo.tx_fifo_wen   <= 1'b0;
      fifo.tx_fifo_wdata <= '0;
    end else begin
      frame_done       <= '0;
      fifo.tx_fifo_wen <= do_write;
      if (do_write) begin
        fifo.tx_fifo_wdata <= sel_byte;
        rem                <= rem - 8'd1;
      end
      if (do_grant) begin
        gnt     <= pick_oh;
        win_idx <= pick_idx;
        rem     <= pick_len;
      end
      if (do_finish) begin
        frame_done <= gnt;
        gnt        <= '0;
        last       <= win_idx;
      end
      // Two GAP cycles: usedw catches up and the producer can drop req.
      gap_cnt <= (state == GAP) ? ~gap_cnt : 1'b0;
    end
  end

  // Counter saturates at STALL_LIM, so a long stall raises err_stall only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      err_stall <= 1'b0;
    end else begin
      err_stall <= 1'b0;
      if ((state == XFER) && fifo.tx_fifo_full) begin
        if (stall_cnt != 8'(STALL_LIM)) stall_cnt <= stall_cnt + 8'd1;
        if (stall_cnt == 8'(STALL_LIM - 1)) err_stall <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with two producers
module tb_uart_tx_sched;

  localparam int N = 2;

  logic           clk;
  logic           rst;
  logic           ena;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_len;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   src_ack;
  logic [N-1:0]   frame_done;
  logic           err_stall;

  uart_tx_sched_if fifo_if();

  uart_tx_sched #(.N_REQ(N), .HIGH_WM(2000), .STALL_LIM(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .req        (req),
    .req_len    (req_len),
    .src_data   (src_data),
    .gnt        (gnt),
    .src_ack    (src_ack),
    .frame_done (frame_done),
    .err_stall  (err_stall),
    .fifo       (fifo_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] pd0[$], pd1[$], pl0[$], pl1[$], exp_q[$];
  logic [N-1:0] gnt_log[$];

  logic [N-1:0] s_gnt, s_ack, s_fd, prev_gnt;
  logic         s_wen, s_full, s_err, prev_wen, prev_full;
  logic [7:0]   s_wdata;
  int n_wen, wen_run, idle_run, fd_total, frames_seen, n_err, err_at, full_cyc, run_exp, base, k;
  bit run_en, gap_en, fdw_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic drive_prod();
    req[0]         = (pl0.size() > 0);
    req_len[7:0]   = (pl0.size() > 0) ? pl0[0] : 8'd0;
    src_data[7:0]  = (pd0.size() > 0) ? pd0[0] : 8'd0;
    req[1]         = (pl1.size() > 0);
    req_len[15:8]  = (pl1.size() > 0) ? pl1[0] : 8'd0;
    src_data[15:8] = (pd1.size() > 0) ? pd1[0] : 8'd0;
  endtask

  task automatic push_frame(input int p, input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      if (p == 0) pd0.push_back(b);
      else        pd1.push_back(b);
      exp_q.push_back(b);
    end
    if (p == 0) pl0.push_back(8'(len));
    else        pl1.push_back(8'(len));
    drive_prod();
  endtask

  // Observes the DUT mid-cycle; the scoreboard pops on every FIFO write.
  task automatic sample();
    s_gnt   = gnt;
    s_ack   = src_ack;
    s_fd    = frame_done;
    s_wen   = fifo_if.tx_fifo_wen;
    s_wdata = fifo_if.tx_fifo_wdata;
    s_full  = fifo_if.tx_fifo_full;
    s_err   = err_stall;
    if (!rst) begin
      s_ack = '0; s_fd = '0; prev_wen = 1'b0; prev_full = 1'b0; prev_gnt = '0;
      wen_run = 0; idle_run = 0;
      return;
    end
    if (s_wen) begin
      if (gap_en && !prev_wen && frames_seen > 0) chk("frame_gap", 32'(idle_run >= 4), 1);
      idle_run = 0;
      wen_run++;
      n_wen++;
      chk("exp_avail", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("wdata", s_wdata, exp_q.pop_front());
    end else begin
      wen_run = 0;
      idle_run++;
    end
    if (prev_full) begin
      full_cyc++;
      chk("wen_while_full", s_wen, 0);
    end
    if (s_full) chk("ack_while_full", s_ack, 0);
    if (s_err) begin
      n_err++;
      err_at = full_cyc;
    end
    chk("gnt_onehot", 32'($countones(s_gnt) <= 1), 1);
    if (s_gnt != '0 && prev_gnt == '0) gnt_log.push_back(s_gnt);
    if (s_fd != '0) begin
      fd_total++;
      frames_seen++;
      if (fdw_en) chk("fd_with_wen", s_wen, 1);
      if (run_en) chk("frame_run", wen_run, run_exp);
    end
    prev_wen  = s_wen;
    prev_full = s_full;
    prev_gnt  = s_gnt;
  endtask

  // One clock: sample at negedge, then producers advance just after posedge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rst) begin
      if (s_ack[0] && pd0.size() > 0) pd0.delete(0);
      if (s_ack[1] && pd1.size() > 0) pd1.delete(0);
      if (s_fd[0] && pl0.size() > 0)  pl0.delete(0);
      if (s_fd[1] && pl1.size() > 0)  pl1.delete(0);
    end
    drive_prod();
  endtask

  task automatic wait_fd(input int n, input int lim, input string tag);
    int start;
    int cnt;
    start = fd_total;
    cnt   = 0;
    while (fd_total < start + n && cnt < lim) begin
      tick();
      cnt++;
    end
    chk(tag, fd_total - start, n);
  endtask

  task automatic chk_outputs_clear(input string tag);
    chk({tag, "_gnt"},   gnt, 0);
    chk({tag, "_ack"},   src_ack, 0);
    chk({tag, "_fd"},    frame_done, 0);
    chk({tag, "_err"},   err_stall, 0);
    chk({tag, "_wen"},   fifo_if.tx_fifo_wen, 0);
    chk({tag, "_wdata"}, fifo_if.tx_fifo_wdata, 0);
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; req = '0; req_len = '0; src_data = '0;
    fifo_if.tx_fifo_full = 1'b0; fifo_if.tx_fifo_usedw = 12'd0;
    n_wen = 0; wen_run = 0; idle_run = 0; fd_total = 0; frames_seen = 0;
    n_err = 0; err_at = 0; full_cyc = 0; run_exp = 0; base = 0; k = 0;
    prev_wen = 1'b0; prev_full = 1'b0; prev_gnt = '0;
    run_en = 1'b0; gap_en = 1'b0; fdw_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_clear("reset");
    rst = 1'b1;
    tick(); tick();

    // Single frame, len 8, empty FIFO: latency, order, coincident frame_done.
    run_en = 1'b1; run_exp = 8; base = n_wen;
    push_frame(0, 8);
    tick(); chk("t1_no_early_gnt", s_gnt, 0);
    tick(); chk("t1_gnt", s_gnt, 2'b01); chk("t1_wen_k1", s_wen, 0);
    tick(); chk("t1_ack", s_ack, 2'b01); chk("t1_wen_k2", s_wen, 0);
    tick(); chk("t1_first_wen", s_wen, 1);
    wait_fd(1, 20, "t1_done");
    chk("t1_count", n_wen - base, 8);
    chk("t1_gnt_drop", s_gnt, 0);
    chk("t1_sb_empty", exp_q.size(), 0);
    run_en = 1'b0;
    repeat (4) tick();

    // Fresh reset (last = 1), two producers: grants 0,1,0,1 with spacing.
    rst = 1'b0; tick(); rst = 1'b1; tick();
    frames_seen = 0; gnt_log.delete(); gap_en = 1'b1;
    push_frame(0, 5); push_frame(1, 4); push_frame(0, 3); push_frame(1, 6);
    wait_fd(4, 200, "t2_done");
    chk("t2_ngnt", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", (gnt_log.size() > i) ? 32'(gnt_log[i]) : 32'd0, (i % 2 == 0) ? 32'd1 : 32'd2);
    chk("t2_sb_empty", exp_q.size(), 0);
    gap_en = 1'b0;
    repeat (4) tick();

    // Watermark: 1990+16 and 1985+16 hold in CHECK; 1984+16 = 2000 proceeds.
    fifo_if.tx_fifo_usedw = 12'd1990; base = n_wen;
    push_frame(0, 16);
    repeat (8) tick();
    chk("t3_hold_gnt", s_gnt, 2'b01);
    chk("t3_hold_nowen", n_wen - base, 0);
    chk("t3_hold_noack", s_ack, 0);
    fifo_if.tx_fifo_usedw = 12'd1985;
    repeat (4) tick();
    chk("t3_edge_nowen", n_wen - base, 0);
    chk("t3_edge_gnt", s_gnt, 2'b01);
    fifo_if.tx_fifo_usedw = 12'd1984; run_en = 1'b1; run_exp = 16;
    wait_fd(1, 40, "t3_done");
    chk("t3_count", n_wen - base, 16);
    chk("t3_sb_empty", exp_q.size(), 0);
    run_en = 1'b0; fifo_if.tx_fifo_usedw = 12'd0;
    repeat (4) tick();

    // FIFO full for 300 cycles mid-frame.
    base = n_wen; n_err = 0; err_at = 0;
    push_frame(1, 20);
    k = 0;
    while (n_wen - base < 5 && k < 30) begin tick(); k++; end
    chk("t4_pre", n_wen - base, 5);
    fifo_if.tx_fifo_full = 1'b1; full_cyc = 0;
    repeat (300) tick();
    chk("t4_during_full", n_wen - base, 6);
    chk("t4_gnt_held", s_gnt, 2'b10);
    fifo_if.tx_fifo_full = 1'b0;
    wait_fd(1, 60, "t4_done");
    chk("t4_count", n_wen - base, 20);
    chk("t4_sb_empty", exp_q.size(), 0);
    chk("t4_err_once", n_err, 1);
    chk("t4_err_at", err_at, 255);
    repeat (4) tick();

    // Zero-length frame.
    fdw_en = 1'b0; base = n_wen;
    push_frame(0, 0);
    wait_fd(1, 20, "t5_zero_done");
    chk("t5_zero_wen", n_wen - base, 0);
    fdw_en = 1'b1;
    repeat (4) tick();

    // ena low blocks grants; then reset mid-frame and a clean fresh frame.
    ena = 1'b0; base = n_wen;
    push_frame(1, 10); push_frame(0, 10);
    repeat (10) tick();
    chk("t5_ena_nognt", s_gnt, 0);
    chk("t5_ena_nowen", n_wen - base, 0);
    ena = 1'b1;
    k = 0;
    while (n_wen - base < 3 && k < 20) begin tick(); k++; end
    chk("t5_started", n_wen - base, 3);
    rst = 1'b0;
    #1;
    chk_outputs_clear("t5_rst");
    pd0.delete(); pd1.delete(); pl0.delete(); pl1.delete(); exp_q.delete();
    drive_prod();
    tick(); tick();
    rst = 1'b1;
    tick();
    base = n_wen; run_en = 1'b1; run_exp = 6;
    push_frame(1, 6);
    wait_fd(1, 30, "t5_fresh_done");
    chk("t5_fresh_count", n_wen - base, 6);
    chk("t5_fresh_sb_empty", exp_q.size(), 0);
    run_en = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
